// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the execute-stage ALU controller: opcode map,
// ALU select and CCR bit positions, and the controller state encoding.
package alu_ctrl_pkg;

    localparam int OP_W  = 5;
    localparam int SEL_W = 12;
    localparam int CCR_W = 3;

    localparam logic [OP_W-1:0] OP_NOP  = 5'd0;
    localparam logic [OP_W-1:0] OP_SETC = 5'd1;
    localparam logic [OP_W-1:0] OP_CLRC = 5'd2;
    localparam logic [OP_W-1:0] OP_NOT  = 5'd3;
    localparam logic [OP_W-1:0] OP_INC  = 5'd4;
    localparam logic [OP_W-1:0] OP_DEC  = 5'd5;
    localparam logic [OP_W-1:0] OP_IN   = 5'd6;
    localparam logic [OP_W-1:0] OP_MOV  = 5'd7;
    localparam logic [OP_W-1:0] OP_ADD  = 5'd8;
    localparam logic [OP_W-1:0] OP_SUB  = 5'd9;
    localparam logic [OP_W-1:0] OP_AND  = 5'd10;
    localparam logic [OP_W-1:0] OP_OR   = 5'd11;
    localparam logic [OP_W-1:0] OP_SHL  = 5'd12;
    localparam logic [OP_W-1:0] OP_SHR  = 5'd13;
    localparam logic [OP_W-1:0] OP_LDM  = 5'd14;

    localparam int SEL_MOV = 0;
    localparam int SEL_ADD = 1;
    localparam int SEL_NOT = 2;
    localparam int SEL_INC = 3;
    localparam int SEL_DEC = 4;
    localparam int SEL_SUB = 5;
    localparam int SEL_AND = 6;
    localparam int SEL_OR  = 7;
    localparam int SEL_SHL = 8;
    localparam int SEL_SHR = 9;
    localparam int SEL_IN  = 10;
    localparam int SEL_LDM = 11;

    localparam int CCR_Z = 0;
    localparam int CCR_N = 1;
    localparam int CCR_C = 2;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_SAVE    = 2'd1,
        ST_HOLD    = 2'd2,
        ST_RESTORE = 2'd3
    } ctrl_state_e;

    function automatic logic [SEL_W-1:0] sel_bit(input int unsigned idx);
        sel_bit = {{(SEL_W-1){1'b0}}, 1'b1} << idx;
    endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational opcode decode: ALU one-hot select plus per-opcode CCR
// update controls. Undefined opcodes select nothing and flag illegal.
module alu_op_decode
    import alu_ctrl_pkg::*;
(
    input  logic [4:0]  opcode,
    output logic [11:0] alu_sel,
    output logic        zn_upd,
    output logic        c_upd,
    output logic        c_set,
    output logic        c_clr,
    output logic        illegal
);

    // opcode to select line and flag-update class
    always_comb begin
        alu_sel = {SEL_W{1'b0}};
        zn_upd  = 1'b0;
        c_upd   = 1'b0;
        c_set   = 1'b0;
        c_clr   = 1'b0;
        illegal = 1'b0;
        case (opcode)
            OP_NOP:  alu_sel = {SEL_W{1'b0}};
            OP_SETC: c_set   = 1'b1;
            OP_CLRC: c_clr   = 1'b1;
            OP_NOT: begin
                alu_sel = sel_bit(SEL_NOT);
                zn_upd  = 1'b1;
            end
            OP_INC: begin
                alu_sel = sel_bit(SEL_INC);
                zn_upd  = 1'b1;
            end
            OP_DEC: begin
                alu_sel = sel_bit(SEL_DEC);
                zn_upd  = 1'b1;
            end
            OP_IN:  alu_sel = sel_bit(SEL_IN);
            OP_MOV: alu_sel = sel_bit(SEL_MOV);
            OP_ADD: begin
                alu_sel = sel_bit(SEL_ADD);
                zn_upd  = 1'b1;
                c_upd   = 1'b1;
            end
            OP_SUB: begin
                alu_sel = sel_bit(SEL_SUB);
                zn_upd  = 1'b1;
            end
            OP_AND: begin
                alu_sel = sel_bit(SEL_AND);
                zn_upd  = 1'b1;
            end
            OP_OR: begin
                alu_sel = sel_bit(SEL_OR);
                zn_upd  = 1'b1;
            end
            OP_SHL: begin
                alu_sel = sel_bit(SEL_SHL);
                zn_upd  = 1'b1;
            end
            OP_SHR: begin
                alu_sel = sel_bit(SEL_SHR);
                zn_upd  = 1'b1;
            end
            OP_LDM:  alu_sel = sel_bit(SEL_LDM);
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_ctrl.sv
// Execute-stage ALU controller: gates the decoded ALU select, owns the
// architectural CCR and its interrupt shadow, and sequences INT entry / RTI.
module alu_ctrl
    import alu_ctrl_pkg::*;
#(
    parameter int INT_CYCLES = 2,
    parameter int CNT_W      = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        op_valid,
    input  logic [4:0]  opcode,
    input  logic        stall,
    input  logic        flush,
    input  logic [2:0]  ccr_alu,
    input  logic [2:0]  flag_clr,
    input  logic        int_req,
    input  logic        rti_req,
    output logic [11:0] alu_sel,
    output logic [2:0]  ccr,
    output logic        busy,
    output logic        int_ack,
    output logic        rti_ack,
    output logic        illegal
);

    ctrl_state_e       state_r;
    ctrl_state_e       state_nxt_s;
    logic [CNT_W-1:0]  cnt_r;
    logic [CNT_W-1:0]  cnt_nxt_s;
    logic [CCR_W-1:0]  ccr_r;
    logic [CCR_W-1:0]  ccr_nxt_s;
    logic [CCR_W-1:0]  ccr_cleared_s;
    logic [CCR_W-1:0]  shadow_r;
    logic [CCR_W-1:0]  shadow_nxt_s;
    logic              illegal_r;
    logic              illegal_nxt_s;
    logic              accept_s;

    logic [SEL_W-1:0]  dec_sel_s;
    logic              dec_zn_upd_s;
    logic              dec_c_upd_s;
    logic              dec_c_set_s;
    logic              dec_c_clr_s;
    logic              dec_illegal_s;

    alu_op_decode u_decode (
        .opcode  (opcode),
        .alu_sel (dec_sel_s),
        .zn_upd  (dec_zn_upd_s),
        .c_upd   (dec_c_upd_s),
        .c_set   (dec_c_set_s),
        .c_clr   (dec_c_clr_s),
        .illegal (dec_illegal_s)
    );

    assign accept_s = op_valid & ~stall & ~flush & (state_r == ST_RUN);
    assign ccr      = ccr_r;
    assign illegal  = illegal_r;

    // controller state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_RUN;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // next-state logic; requests are only sampled in RUN, INT before RTI
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_RUN: begin
                if (int_req) begin
                    state_nxt_s = ST_SAVE;
                end else if (rti_req) begin
                    state_nxt_s = ST_RESTORE;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_SAVE:    state_nxt_s = ST_HOLD;
            ST_HOLD: begin
                if (cnt_r == {CNT_W{1'b0}}) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_HOLD;
                end
            end
            ST_RESTORE: state_nxt_s = ST_RUN;
            default:    state_nxt_s = ST_RUN;
        endcase
    end

    // outputs decoded from the current state and accept
    always_comb begin
        alu_sel = accept_s ? dec_sel_s : {SEL_W{1'b0}};
        busy    = (state_r != ST_RUN);
        int_ack = (state_r == ST_HOLD) && (cnt_r == {CNT_W{1'b0}});
        rti_ack = (state_r == ST_RESTORE);
    end

    // CCR, shadow and hold-counter next values; an accepted op overrides flag_clr
    always_comb begin
        ccr_cleared_s = ccr_r & ~flag_clr;
        ccr_nxt_s     = ccr_cleared_s;
        shadow_nxt_s  = shadow_r;
        cnt_nxt_s     = cnt_r;
        illegal_nxt_s = accept_s & dec_illegal_s;
        case (state_r)
            ST_RUN: begin
                ccr_nxt_s[CCR_Z] = (accept_s & dec_zn_upd_s) ? ccr_alu[CCR_Z] : ccr_cleared_s[CCR_Z];
                ccr_nxt_s[CCR_N] = (accept_s & dec_zn_upd_s) ? ccr_alu[CCR_N] : ccr_cleared_s[CCR_N];
                ccr_nxt_s[CCR_C] = (accept_s & dec_c_upd_s) ? ccr_alu[CCR_C] :
                                   (accept_s & dec_c_set_s) ? 1'b1 :
                                   (accept_s & dec_c_clr_s) ? 1'b0 : ccr_cleared_s[CCR_C];
            end
            ST_SAVE: begin
                shadow_nxt_s = ccr_cleared_s;
                cnt_nxt_s    = CNT_W'(INT_CYCLES - 1);
            end
            ST_HOLD: begin
                cnt_nxt_s = (cnt_r != {CNT_W{1'b0}}) ? (cnt_r - CNT_W'(1)) : cnt_r;
            end
            ST_RESTORE: begin
                ccr_nxt_s = shadow_r;
            end
            default: begin
                ccr_nxt_s = ccr_cleared_s;
            end
        endcase
    end

    // datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ccr_r     <= {CCR_W{1'b0}};
            shadow_r  <= {CCR_W{1'b0}};
            cnt_r     <= {CNT_W{1'b0}};
            illegal_r <= 1'b0;
        end else begin
            ccr_r     <= ccr_nxt_s;
            shadow_r  <= shadow_nxt_s;
            cnt_r     <= cnt_nxt_s;
            illegal_r <= illegal_nxt_s;
        end
    end

endmodule

// File: tb/tb_alu_ctrl.sv
// Scoreboard bench for alu_ctrl: a cycle-level reference model queues the
// expected outputs per cycle, and a monitor compares them at the falling edge.
module tb_alu_ctrl;

    localparam int INT_CYCLES = 2;

    logic        clk;
    logic        rst;
    logic        op_valid;
    logic [4:0]  opcode;
    logic        stall;
    logic        flush;
    logic [2:0]  ccr_alu;
    logic [2:0]  flag_clr;
    logic        int_req;
    logic        rti_req;
    logic [11:0] alu_sel;
    logic [2:0]  ccr;
    logic        busy;
    logic        int_ack;
    logic        rti_ack;
    logic        illegal;

    alu_ctrl #(.INT_CYCLES(INT_CYCLES), .CNT_W(3)) dut (
        .clk      (clk),
        .rst      (rst),
        .op_valid (op_valid),
        .opcode   (opcode),
        .stall    (stall),
        .flush    (flush),
        .ccr_alu  (ccr_alu),
        .flag_clr (flag_clr),
        .int_req  (int_req),
        .rti_req  (rti_req),
        .alu_sel  (alu_sel),
        .ccr      (ccr),
        .busy     (busy),
        .int_ack  (int_ack),
        .rti_ack  (rti_ack),
        .illegal  (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks_total  = 0;
    int checks_passed = 0;
    int cycle_no      = 0;

    // expected {alu_sel, ccr, busy, int_ack, rti_ack, illegal}
    logic [18:0] exp_q[$];

    // reference model state
    bit [2:0] m_ccr;
    bit [2:0] m_shadow;
    bit       m_ill;
    int       m_left;   // busy cycles still to come in the current sequence
    bit       m_rti;

    function automatic int sel_index(input int opc);
        case (opc)
            7:  return 0;
            8:  return 1;
            3:  return 2;
            4:  return 3;
            5:  return 4;
            9:  return 5;
            10: return 6;
            11: return 7;
            12: return 8;
            13: return 9;
            6:  return 10;
            14: return 11;
            default: return -1;
        endcase
    endfunction

    function automatic bit [2:0] apply_op(input bit [2:0] base, input int opc, input bit [2:0] alu);
        if (opc == 8) return alu;
        if (opc == 3 || opc == 4 || opc == 5 || (opc >= 9 && opc <= 13)) return {base[2], alu[1:0]};
        if (opc == 1) return base | 3'b100;
        if (opc == 2) return base & 3'b011;
        return base;
    endfunction

    task automatic model_reset();
        m_ccr = 3'b000; m_shadow = 3'b000; m_ill = 1'b0; m_left = 0; m_rti = 1'b0;
    endtask

    task automatic model_step(input bit v, input bit [4:0] opc, input bit [2:0] alu,
                              input bit [2:0] clr, input bit ir, input bit rr,
                              input bit st, input bit fl);
        bit          busy_m;
        bit          acc;
        int          idx;
        logic [11:0] sel_e;
        bit          ia;
        bit          ra;
        bit [2:0]    cleared;
        busy_m  = (m_left != 0);
        acc     = v && !st && !fl && !busy_m;
        idx     = sel_index(int'(opc));
        sel_e   = (acc && idx >= 0) ? (12'd1 << idx) : 12'd0;
        ia      = busy_m && !m_rti && (m_left == 1);
        ra      = busy_m && m_rti;
        exp_q.push_back({sel_e, m_ccr, busy_m, ia, ra, m_ill});
        cleared = m_ccr & ~clr;
        if (!busy_m) begin
            m_ccr = acc ? apply_op(cleared, int'(opc), alu) : cleared;
            m_ill = acc && (opc > 5'd14);
            if (ir) begin
                m_left = INT_CYCLES + 1; m_rti = 1'b0;
            end else if (rr) begin
                m_left = 1; m_rti = 1'b1;
            end
        end else begin
            m_ill = 1'b0;
            if (m_rti) begin
                m_ccr = m_shadow;
            end else begin
                m_ccr = cleared;
                if (m_left == INT_CYCLES + 1) m_shadow = cleared;
            end
            m_left--;
        end
    endtask

    task automatic cyc(input bit v, input bit [4:0] opc, input bit [2:0] alu,
                       input bit [2:0] clr = 3'b000, input bit ir = 1'b0, input bit rr = 1'b0,
                       input bit st = 1'b0, input bit fl = 1'b0);
        @(posedge clk);
        #1;
        op_valid = v; opcode = opc; ccr_alu = alu; flag_clr = clr;
        int_req = ir; rti_req = rr; stall = st; flush = fl;
        model_step(v, opc, alu, clr, ir, rr, st, fl);
    endtask

    task automatic check(input string name, input int got, input int want);
        checks_total++;
        if (got == want) checks_passed++;
        else $display("FAIL %s: got %0h want %0h", name, got, want);
    endtask

    // monitor: one scoreboard comparison per clock, away from the rising edge
    logic [18:0] mon_want;
    logic [18:0] mon_got;
    always @(negedge clk) begin
        cycle_no++;
        if (!rst && exp_q.size() != 0) begin
            mon_want = exp_q.pop_front();
            mon_got  = {alu_sel, ccr, busy, int_ack, rti_ack, illegal};
            checks_total++;
            if (mon_got === mon_want) begin
                checks_passed++;
            end else begin
                $display("FAIL outputs cycle %0d: got sel=%h ccr=%b busy=%b iack=%b rack=%b ill=%b want sel=%h ccr=%b busy=%b iack=%b rack=%b ill=%b",
                         cycle_no, mon_got[18:7], mon_got[6:4], mon_got[3], mon_got[2], mon_got[1], mon_got[0],
                         mon_want[18:7], mon_want[6:4], mon_want[3], mon_want[2], mon_want[1], mon_want[0]);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic reset_checks(input string tag);
        check({tag, "_ccr"},     int'(ccr),     0);
        check({tag, "_busy"},    int'(busy),    0);
        check({tag, "_alu_sel"}, int'(alu_sel), 0);
        check({tag, "_int_ack"}, int'(int_ack), 0);
        check({tag, "_rti_ack"}, int'(rti_ack), 0);
        check({tag, "_illegal"}, int'(illegal), 0);
    endtask

    bit       r_v, r_ir, r_rr, r_st, r_fl;
    bit [4:0] r_op;
    bit [2:0] r_alu, r_clr;

    initial begin
        rst = 1'b1; op_valid = 1'b0; opcode = 5'd0; stall = 1'b0; flush = 1'b0;
        ccr_alu = 3'b000; flag_clr = 3'b000; int_req = 1'b0; rti_req = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset_checks("por");
        rst = 1'b0;

        // ADD then MOV
        cyc(1, 5'd8, 3'b101);
        cyc(1, 5'd7, 3'b010);
        // SUB keeps C; SETC / CLRC
        cyc(1, 5'd8, 3'b100);
        cyc(1, 5'd9, 3'b110);
        cyc(1, 5'd1, 3'b000);
        cyc(1, 5'd2, 3'b111);
        // interrupt entry with a same-cycle ADD, then RTI
        cyc(1, 5'd8, 3'b011);
        cyc(1, 5'd8, 3'b100, 3'b000, 1'b1);
        repeat (3) cyc(1, 5'd4, 3'b001, 3'b000, 1'b1);
        cyc(1, 5'd4, 3'b001);
        cyc(0, 5'd0, 3'b000, 3'b000, 1'b0, 1'b1);
        cyc(0, 5'd0, 3'b000, 3'b000, 1'b0, 1'b1);
        cyc(0, 5'd0, 3'b000);
        // both requests: INT first, RTI taken right after the ack
        cyc(1, 5'd8, 3'b111);
        repeat (4) cyc(0, 5'd0, 3'b000, 3'b000, 1'b1, 1'b1);
        cyc(0, 5'd0, 3'b000, 3'b000, 1'b0, 1'b1);
        cyc(0, 5'd0, 3'b000, 3'b000, 1'b0, 1'b1);
        cyc(0, 5'd0, 3'b000);
        // flag_clr against an AND that sets Z
        cyc(1, 5'd1, 3'b000);
        cyc(1, 5'd10, 3'b001, 3'b001);
        cyc(0, 5'd0, 3'b000, 3'b111);
        // illegal opcode, stall, flush
        cyc(1, 5'd8, 3'b110);
        cyc(1, 5'd20, 3'b001);
        cyc(0, 5'd0, 3'b000);
        cyc(1, 5'd8, 3'b001, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc(1, 5'd8, 3'b001, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc(0, 5'd0, 3'b000);
        // reset in the middle of HOLD, then RTI must restore a cleared shadow
        cyc(1, 5'd8, 3'b111);
        cyc(0, 5'd0, 3'b000, 3'b000, 1'b1);
        cyc(0, 5'd0, 3'b000, 3'b000, 1'b1);
        cyc(0, 5'd0, 3'b000, 3'b000, 1'b1);
        @(posedge clk);
        #1;
        op_valid = 1'b1; opcode = 5'd8; int_req = 1'b0; flag_clr = 3'b000;
        check("busy_before_rst", int'(busy), 1);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_alu_sel_op_valid", int'(alu_sel), 2);
        op_valid = 1'b0;
        #1;
        reset_checks("mid_rst");
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        cyc(1, 5'd8, 3'b111);
        cyc(0, 5'd0, 3'b000, 3'b000, 1'b0, 1'b1);
        cyc(0, 5'd0, 3'b000, 3'b000, 1'b0, 1'b1);
        cyc(0, 5'd0, 3'b000);

        // randomized traffic
        r_ir = 1'b0; r_rr = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            r_v   = ($urandom_range(0, 3) != 0);
            r_op  = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(15, 31)) : 5'($urandom_range(0, 14));
            r_alu = 3'($urandom);
            r_clr = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b000;
            r_st  = ($urandom_range(0, 7) == 0);
            r_fl  = ($urandom_range(0, 7) == 0);
            if (!r_ir) r_ir = ($urandom_range(0, 19) == 0);
            else       r_ir = ($urandom_range(0, 5) != 0);
            if (!r_rr) r_rr = ($urandom_range(0, 19) == 0);
            else       r_rr = ($urandom_range(0, 5) != 0);
            cyc(r_v, r_op, r_alu, r_clr, r_ir, r_rr, r_st, r_fl);
        end
        cyc(0, 5'd0, 3'b000);

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            checks_total++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
